// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if: bundles the requester-side and I2C-master-side signals of
// the two-requester I2C arbiter. Signal suffixes are from the arbiter's
// point of view (_i into the arbiter, _o out of it).
//
// Handshake: a requester raises req_i[n] as a level and holds it. Once
// gnt_o[n] is seen, it may issue one wr_i[n] or rd_i[n] pulse with its
// fields valid in that same cycle. It then keeps req_i[n] high until
// done_o[n] pulses. Dropping req_i[n] while granted but before a pulse
// withdraws the request with no done_o. data_valid_o[n] qualifies data_o
// in the cycle it is high. There is no back-pressure on any return path.
interface i2c_arbiter_if;
  // requester side
  logic [1:0]  req_i;
  logic [1:0]  wr_i;
  logic [1:0]  rd_i;
  logic [15:0] slave_addr_i;
  logic [15:0] din_i;
  logic [15:0] cmd_i;
  logic [15:0] nbytes_i;
  logic [1:0]  gnt_o;
  logic [1:0]  done_o;
  logic [1:0]  data_valid_o;
  logic [7:0]  data_o;
  logic        rxak_o;
  logic        arb_lost_o;
  logic        timeout_o;
  // I2C master side
  logic        i2c_busy_i;
  logic        i2c_write_done_i;
  logic        i2c_data_out_valid_i;
  logic        i2c_rxak_i;
  logic        i2c_arb_lost_i;
  logic [7:0]  i2c_data_out_i;
  logic        i2c_write_o;
  logic        i2c_read_o;
  logic [7:0]  i2c_slave_addr_o;
  logic [7:0]  i2c_din_o;
  logic [7:0]  i2c_command_byte_o;
  logic [7:0]  i2c_num_bytes_o;

  // arbiter view
  modport master (
    input  req_i, wr_i, rd_i, slave_addr_i, din_i, cmd_i, nbytes_i,
    input  i2c_busy_i, i2c_write_done_i, i2c_data_out_valid_i,
    input  i2c_rxak_i, i2c_arb_lost_i, i2c_data_out_i,
    output gnt_o, done_o, data_valid_o, data_o, rxak_o, arb_lost_o, timeout_o,
    output i2c_write_o, i2c_read_o, i2c_slave_addr_o, i2c_din_o,
    output i2c_command_byte_o, i2c_num_bytes_o
  );

  // environment view (requesters plus I2C master)
  modport slave (
    output req_i, wr_i, rd_i, slave_addr_i, din_i, cmd_i, nbytes_i,
    output i2c_busy_i, i2c_write_done_i, i2c_data_out_valid_i,
    output i2c_rxak_i, i2c_arb_lost_i, i2c_data_out_i,
    input  gnt_o, done_o, data_valid_o, data_o, rxak_o, arb_lost_o, timeout_o,
    input  i2c_write_o, i2c_read_o, i2c_slave_addr_o, i2c_din_o,
    input  i2c_command_byte_o, i2c_num_bytes_o
  );
endinterface

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one I2C master between two requesters.
// The grant is held from a request until the master goes idle again. The
// owner's fields are latched on its start pulse. Completion, status and read
// data are returned only to the owner.
// Optional feature macro: I2C_ARB_TIMEOUT_EN. When it is defined, a stuck
// transfer is force-released TIMEOUT_CYCLES cycles after LAUNCH (minimum 2).
// When it is undefined, no counter is built and timeout_o is 0.
module i2c_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic            clk_i,
  input  logic            reset_i,
  i2c_arbiter_if.master   bus,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RELEASE   = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic       op_wr_q, op_wr_d;
  logic       latch_en;
  logic [1:0] owner_oh;
  logic       owner_pulse;
  logic       in_wait;
  logic [7:0] addr_q, din_q, cmd_q, nbytes_q;
  logic [7:0] data_q;
  logic       rxak_q, arb_lost_q;
  logic [1:0] data_valid_q;

  // Completion is taken from busy falling, so write_done carries no extra information.
  logic unused_write_done;
  assign unused_write_done = bus.i2c_write_done_i;

  assign owner_oh    = owner_q ? 2'b10 : 2'b01;
  assign owner_pulse = bus.wr_i[owner_q] | bus.rd_i[owner_q];
  assign in_wait     = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);

`ifdef I2C_ARB_TIMEOUT_EN
  // Counter value c in the wait states means c+1 wait cycles have elapsed.
  // Firing at TIMEOUT_CYCLES-2 lands RELEASE TIMEOUT_CYCLES cycles after LAUNCH.
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             to_hit;

  assign to_hit = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 2));

  // Timeout counter and sticky "this release was forced" flag, both cleared on LAUNCH.
  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if (state_q == S_LAUNCH) begin
      cnt_d = '0;
      to_d  = 1'b0;
    end else if (in_wait) begin
      cnt_d = cnt_q + 1'b1;
      if (to_hit) to_d = 1'b1;
    end
  end

  // Timeout counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign bus.timeout_o = (state_q == S_RELEASE) && to_q;
`else
  // The parameter has no effect in this build; it is kept so instantiations match.
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign bus.timeout_o = 1'b0;
`endif

  // Next-state logic: owner selection, launch and release sequencing.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    op_wr_d      = op_wr_q;
    latch_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A busy master means some other user still holds the bus.
        if ((bus.req_i != 2'b00) && !bus.i2c_busy_i) begin
          state_d = S_GRANT;
          case (bus.req_i)
            2'b01:   owner_d = 1'b0;
            2'b10:   owner_d = 1'b1;
            default: owner_d = ~last_owner_q;
          endcase
        end
      end
      S_GRANT: begin
        if (owner_pulse) begin
          latch_en = 1'b1;
          op_wr_d  = bus.wr_i[owner_q];  // write wins when both pulse
          state_d  = S_LAUNCH;
        end else if (!bus.req_i[owner_q]) begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (bus.i2c_busy_i)  state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!bus.i2c_busy_i) state_d = S_RELEASE;
      S_RELEASE: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef I2C_ARB_TIMEOUT_EN
    if (in_wait && to_hit) state_d = S_RELEASE;
`endif
  end

  // FSM and ownership registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;  // requester 0 wins the first tie
      op_wr_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      op_wr_q      <= op_wr_d;
    end
  end

  // Field latch: the owner's byte lane is captured on its start pulse and held.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q   <= 8'h00;
      din_q    <= 8'h00;
      cmd_q    <= 8'h00;
      nbytes_q <= 8'h00;
    end else if (latch_en) begin
      addr_q   <= bus.slave_addr_i[{owner_q, 3'b000} +: 8];
      din_q    <= bus.din_i[{owner_q, 3'b000} +: 8];
      cmd_q    <= bus.cmd_i[{owner_q, 3'b000} +: 8];
      nbytes_q <= bus.nbytes_i[{owner_q, 3'b000} +: 8];
    end
  end

  // Return path: status and data are sampled every cycle; valid is owner-gated.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q       <= 8'h00;
      rxak_q       <= 1'b0;
      arb_lost_q   <= 1'b0;
      data_valid_q <= 2'b00;
    end else begin
      data_q       <= bus.i2c_data_out_i;
      rxak_q       <= bus.i2c_rxak_i;
      arb_lost_q   <= bus.i2c_arb_lost_i;
      data_valid_q <= ((state_q == S_WAIT_DONE) && bus.i2c_data_out_valid_i) ? owner_oh : 2'b00;
    end
  end

  assign bus.gnt_o              = (state_q != S_IDLE) ? owner_oh : 2'b00;
  assign bus.done_o             = (state_q == S_RELEASE) ? owner_oh : 2'b00;
  assign bus.i2c_write_o        = (state_q == S_LAUNCH) && op_wr_q;
  assign bus.i2c_read_o         = (state_q == S_LAUNCH) && !op_wr_q;
  assign bus.i2c_slave_addr_o   = addr_q;
  assign bus.i2c_din_o          = din_q;
  assign bus.i2c_command_byte_o = cmd_q;
  assign bus.i2c_num_bytes_o    = nbytes_q;
  assign bus.data_o             = data_q;
  assign bus.rxak_o             = rxak_q;
  assign bus.arb_lost_o         = arb_lost_q;
  assign bus.data_valid_o       = data_valid_q;
  assign dbg_state_o            = state_q;

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Two-requester arbiter that shares the single I2C master between independent sensor sequencers, e.g. the level/accelerometer FSM and a second polling FSM. It grants the master to one requester at a time, round-robin. It latches the granted requester's transaction fields, issues the write/read start pulse, and holds ownership until the master goes idle. Completion, status and read data go back only to the owner.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 100000: cycles allowed in WAIT_BUSY+WAIT_DONE before forced release.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; one clock; reset is synchronous and active-high.
- req_i  in  2  per-requester level request; bit n = requester n.
- wr_i, rd_i  in  2  per-requester one-cycle start pulses; honoured only from the granted requester in GRANT.
- slave_addr_i, din_i, cmd_i, nbytes_i  in  16  packed fields, {req1[15:8], req0[7:0]}.
- gnt_o  out  2  one-hot grant.
- done_o  out  2  one-cycle completion pulse to owner.
- data_valid_o  out  2  owner-gated copy of i2c_data_out_valid_i.
- data_o  out  8  i2c_data_out_i, registered.
- rxak_o, arb_lost_o  out  1  master status, registered.
- timeout_o  out  1  one-cycle pulse on forced release.
- i2c_busy_i, i2c_write_done_i, i2c_data_out_valid_i, i2c_rxak_i, i2c_arb_lost_i  in  1  master status.
- i2c_data_out_i  in  8  master read data.
- i2c_write_o, i2c_read_o  out  1  one-cycle start pulses to master.
- i2c_slave_addr_o, i2c_din_o, i2c_command_byte_o, i2c_num_bytes_o  out  8  latched fields to master.

## Operation
- States: IDLE, GRANT, LAUNCH, WAIT_BUSY, WAIT_DONE, RELEASE.
- IDLE:
  - If any req_i bit is set and i2c_busy_i=0, select the owner and go to GRANT with gnt_o[owner]=1.
  - If only one requester is active, select it. If both are active, select the one that is not last_owner.
- GRANT:
  - A wr_i or rd_i pulse from the owner latches that owner's four fields and the op type, then goes to LAUNCH.
  - If wr and rd pulse together, the op is a write.
  - If req_i[owner] drops without a pulse, drop gnt_o and return to IDLE. No done_o is issued.
- LAUNCH: assert i2c_write_o or i2c_read_o for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: go to WAIT_DONE when i2c_busy_i=1.
- WAIT_DONE:
  - Forward i2c_data_out_valid_i to data_valid_o[owner] only.
  - On i2c_busy_i=0, go to RELEASE.
- RELEASE:
  - Pulse done_o[owner] for one cycle.
  - Clear gnt_o and set last_owner=owner.
  - Go to IDLE.
- Pulses from the non-owner, and pulses in any state other than GRANT, are ignored.
- Latched fields stay stable on the master outputs from LAUNCH until the next latch.
- rxak_o, arb_lost_o and data_o are sampled every cycle. They are valid to the owner when done_o pulses. The arbiter does not interpret ACK polarity; requesters check it.
- Reset:
  - State is IDLE and last_owner=1, so requester 0 wins the first tie.
  - All outputs are 0, including the latched fields.
  - Reset mid-transaction abandons ownership; no done_o is issued.

## Timing
- req_i seen in IDLE at cycle 0 → gnt_o at cycle 1.
- Owner pulse at cycle k in GRANT → fields latched at k; i2c_write_o/i2c_read_o high at cycle k+1 only.
- i2c_busy_i falling at cycle m in WAIT_DONE → done_o at m+1 and gnt_o low at m+2.
- At the earliest, the next grant appears at m+3.
- data_valid_o lags i2c_data_out_valid_i by 1 cycle, aligned with data_o.
- i2c_busy_i=1 in IDLE blocks granting, which prevents launching while an external user still holds the bus.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - A counter clears on LAUNCH and increments in WAIT_BUSY/WAIT_DONE.
  - Reaching TIMEOUT_CYCLES forces RELEASE with timeout_o and done_o[owner] pulsing together.
- I2C_ARB_TIMEOUT_EN undefined:
  - No counter is built and timeout_o is tied 0.
  - The arbiter waits indefinitely for i2c_busy_i.

## Test plan
- Single requester: req_i=01, wr pulse with addr 8'hD0, cmd 8'h6B, nbytes 2.
  - Required: i2c_write_o is a 1-cycle pulse.
  - Required: i2c_slave_addr_o=D0 and i2c_command_byte_o=6B.
  - Required: after busy 1→0, done_o=01 for 1 cycle.
- Contention: req_i=11 from reset.
  - Required: grants go 01, then 10, then 01 across three back-to-back transactions.
- Read: owner 1 issues rd; master pulses data_out_valid with 8'hF9.
  - Required: data_valid_o=10 and data_o=F9.
  - Required: data_valid_o[0] never asserts.
- Non-owner pulse: owner 0 is granted and requester 1 pulses wr.
  - Required: no i2c_write_o and no latched field change.
- Timeout (macro on, TIMEOUT_CYCLES=16): busy never rises after launch.
  - Required: timeout_o and done_o[owner] pulse 16 cycles after LAUNCH.
  - Required: next grant proceeds.
- Reset mid-WAIT_DONE.
  - Required: all outputs 0 the next cycle and no done_o.
  - Required: requester 0 wins the next tie.
